// File: rtl/dmem_responder_pkg.sv
// Shared constants and encodings for the memory-stage data responder.
// Imported by the responder top; the RAM sub-module is type-agnostic.
package dmem_responder_pkg;

    localparam int unsigned DWIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // OP_BOTH captures rd and wr asserted together so it can be flagged later.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_LD   = 2'b01,
        OP_ST   = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    function automatic op_e op_encode(input logic rd_en, input logic wr_en);
        return op_e'({wr_en, rd_en});
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM: write-enable port plus a registered read.
// Contents are intentionally not reset.
module dmem_array #(
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];
    logic [DWIDTH-1:0] rdata_q;
    logic [DWIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = mem_q[addr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store in IDLE, waits
// WAIT_CYCLES, performs the access in RESP and pulses ack/err afterwards.
module dmem_responder #(
    parameter int unsigned DWIDTH      = dmem_responder_pkg::DWIDTH,
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              d_clk,
    input  logic              d_rst,
    input  logic              r_i_ce,
    input  logic              r_i_rd_en,
    input  logic              r_i_wr_en,
    input  logic [DWIDTH-1:0] r_i_addr,
    input  logic [DWIDTH-1:0] r_i_store_data,
    output logic [DWIDTH-1:0] r_o_load_data,
    output logic              r_o_ack,
    output logic              r_o_err,
    output logic              r_o_stall
);

    import dmem_responder_pkg::*;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    op_e               op_q, op_d;
    logic [DWIDTH-1:0] ld_q, ld_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    logic                  req_valid;
    logic                  acc_err;
    logic [DWIDTH-3:0]     word_idx;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DWIDTH-1:0]     ram_rdata;

    assign req_valid = r_i_ce && (r_i_rd_en || r_i_wr_en);
    assign word_idx  = addr_q[DWIDTH-1:2];
    assign acc_err   = (addr_q[1:0] != 2'b00)
                    || ((word_idx >> DEPTH_LOG2) != '0)
                    || (op_q == OP_BOTH);

    // The RAM read is registered, so the address must be presented one cycle
    // ahead of RESP: straight from the inputs when IDLE jumps directly to RESP.
    assign ram_addr = (state_q == IDLE) ? r_i_addr[DEPTH_LOG2+1:2]
                                        : addr_q[DEPTH_LOG2+1:2];
    assign ram_we   = (state_q == RESP) && !acc_err && (op_q == OP_ST);

    dmem_array #(
        .AWIDTH(DEPTH_LOG2),
        .DWIDTH(DWIDTH)
    ) u_array (
        .clk  (d_clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        ld_d    = ld_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = r_i_addr;
                    wdata_d = r_i_store_data;
                    op_d    = op_encode(r_i_rd_en, r_i_wr_en);
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ack_d   = 1'b1;
                err_d   = acc_err;
                if (acc_err) begin
                    ld_d = '0;
                end else if (op_q == OP_LD) begin
                    ld_d = ram_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= OP_NONE;
            ld_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            ld_q    <= ld_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Masked in the ack cycle so the pipeline advances even if the next
    // request is already presented; gated by reset so outputs read 0 in reset.
    assign r_o_stall = d_rst && ((state_q != IDLE) || (req_valid && !ack_q));

    assign r_o_load_data = ld_q;
    assign r_o_ack       = ack_q;
    assign r_o_err       = err_q;

endmodule
